line_window_gen: RTL and testbench
==================================

Name: line_window_gen

Overview:
- Upstream neighbour of the 3x3 convolution/filter stage.
- Accepts a raster-order 8-bit grayscale pixel stream from the camera path and buffers the two previous lines.
- Emits one 72-bit 3x3 neighbourhood per interior pixel, with a valid strobe, in the exact packing the filter stage consumes.
- Also tracks frame position and flags end of frame.

Parameters:
- IMG_WIDTH, 640, active pixels per line (≥3).
- IMG_HEIGHT, 480, active lines per frame (≥3).
- DATA_W, 8, bits per pixel. Output width is 9*DATA_W.

Ports:
- i_clk  in  1  single clock for the whole block.
- i_rst  in  1  reset, synchronous, active-high.
- i_pixel  in  DATA_W  incoming pixel.
- i_pixel_valid  in  1  i_pixel is valid this cycle. Gaps are allowed.
- i_sof  in  1  qualified by i_pixel_valid; marks the current pixel as (row 0, col 0).
- o_pixel_data  out  9*DATA_W  3x3 window. Slot k occupies [k*DATA_W +: DATA_W].
- o_pixel_data_valid  out  1  o_pixel_data is valid this cycle (single-cycle strobe).
- o_frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset state: all outputs 0; row/col counters 0; FSM in S_IDLE. Line-buffer contents are don't-care.
- FSM states:
  - S_IDLE: pixels without i_sof are dropped. Accepted i_sof pixel → S_FILL.
  - S_FILL: rows 0–1. When the row counter reaches 2 → S_ACTIVE.
  - S_ACTIVE: rows 2..IMG_HEIGHT-1. After the last pixel → S_IDLE.
- Counters:
  - Advance only on accepted pixels.
  - col wraps from IMG_WIDTH-1 to 0 and increments row.
  - The accepted pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) pulses o_frame_done next cycle and clears the counters.
- Line buffers:
  - Two buffers of IMG_WIDTH x DATA_W, for rows r-1 and r-2, addressed by col.
  - Read is asynchronous, read-before-write within the same cycle.
  - At col c, the old r-1 entry moves into the r-2 buffer and the new pixel is written to the r-1 buffer. Equivalent rotating-pointer schemes are allowed.
- Window:
  - Three 3-entry column shift registers (top/mid/bottom rows) shift on each accepted pixel.
  - Slot order is row-major with slot 0 = top-left (row r-2, col c-2), slot 4 = centre (r-1, c-1), slot 8 = bottom-right (r, c) = newest pixel.
- Output valid and latency:
  - o_pixel_data_valid = 1 exactly one cycle after accepting pixel (r,c) with r≥2 and c≥2.
  - Otherwise o_pixel_data_valid = 0 and o_pixel_data holds its last value.
  - Latency is 1 cycle. Windows never straddle lines, because cols 0–1 of each row refill the shift registers.
- Boundary conditions:
  - No edge replication: (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows per frame.
  - i_pixel_valid gaps (any length, including mid-line) change nothing but the timing.
  - i_sof in any state restarts the current pixel at (0,0) in S_FILL; no window is emitted for it. An aborted frame gives no o_frame_done.
  - Reset mid-frame returns to S_IDLE; the next frame requires i_sof.
  - If i_sof coincides with the last pixel of a frame, i_sof wins: (0,0), no o_frame_done.

Decomposition:
- Shared package: DATA_W, window slot count (9), slot index constants (TOP_LEFT=0, CENTRE=4, NEWEST=8), FSM state encoding.
- One sub-module, line_buffer: single-port IMG_WIDTH x DATA_W array with async read and sync write. Instantiated twice.

Test Plan (IMG_WIDTH=5, IMG_HEIGHT=4, pixel value = row*16+col):
- Full frame, i_sof on first pixel, continuous valid:
  - First window 1 cycle after pixel (2,2), with slots 0..8 = 00,01,02,10,11,12,20,21,22.
  - Exactly 6 windows; last window slots = 12,13,14,22,23,24,32,33,34.
  - o_frame_done pulses once, 1 cycle after pixel (3,4).
- Same frame with random 0–3 cycle valid gaps: identical window sequence; each window 1 cycle after its completing pixel.
- 7 pixels without i_sof, then a proper frame: the first 7 are dropped, and the windows match the first scenario.
- i_sof reasserted at pixel (2,3) of frame 1, then a full frame: no window for the restart pixel, no o_frame_done for the aborted frame, and the new frame matches the first scenario.
- i_rst asserted for 1 cycle at pixel (3,1): outputs 0 next cycle. A following valid pixel without i_sof produces no window; after i_sof the frame is correct.
- Two back-to-back frames: second frame's first window slots = 00,01,02,10,11,12,20,21,22, with no stale data from frame 1.

Source files
------------

// File: rtl/line_window_gen_pkg.sv
// Shared constants and FSM encoding for the 3x3 line-window generator.
package line_window_gen_pkg;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned SLOTS    = 9;
  localparam int unsigned TOP_LEFT = 0;
  localparam int unsigned CENTRE   = 4;
  localparam int unsigned NEWEST   = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_ACTIVE = 2'd2
  } state_e;
endpackage

// File: rtl/line_window_gen_line_buffer.sv
// One line of pixel storage: asynchronous read, synchronous write, single address.
module line_buffer
  import line_window_gen_pkg::*;
#(
  parameter int unsigned DEPTH  = 640,
  parameter int unsigned WIDTH  = DATA_W,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Read returns the pre-write contents, which the caller relies on to rotate lines.
  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/line_window_gen.sv
// Turns a raster pixel stream into 3x3 neighbourhoods for every interior pixel,
// using two line buffers (rows r-1, r-2) and per-row column history registers.
module line_window_gen
  import line_window_gen_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned DATA_W     = line_window_gen_pkg::DATA_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [DATA_W-1:0]       i_pixel,
  input  logic                    i_pixel_valid,
  input  logic                    i_sof,
  output logic [SLOTS*DATA_W-1:0] o_pixel_data,
  output logic                    o_pixel_data_valid,
  output logic                    o_frame_done
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

  state_e                       state_q;
  logic [COL_W-1:0]             col_q;
  logic [ROW_W-1:0]             row_q;
  // Two oldest columns per row; the third column is the one arriving this cycle.
  logic [1:0][DATA_W-1:0]       top_q, mid_q, bot_q;
  logic [SLOTS-1:0][DATA_W-1:0] win_d;
  logic [DATA_W-1:0]            r1_rd, r2_rd;
  logic [COL_W-1:0]             addr;
  logic                         take, last_col, last_row;

  always_comb begin
    take     = i_pixel_valid && (i_sof || (state_q != S_IDLE));
    addr     = i_sof ? '0 : col_q;
    last_col = (col_q == COL_W'(IMG_WIDTH - 1));
    last_row = (row_q == ROW_W'(IMG_HEIGHT - 1));
    win_d    = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      win_d[TOP_LEFT + k]   = top_q[k];
      win_d[CENTRE - 1 + k] = mid_q[k];
      win_d[NEWEST - 2 + k] = bot_q[k];
    end
    win_d[TOP_LEFT + 2] = r2_rd;
    win_d[CENTRE + 1]   = r1_rd;
    win_d[NEWEST]       = i_pixel;
  end

  // r-1 line takes the new pixel while its old entry moves down into the r-2 line.
  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_W), .ADDR_W(COL_W)) u_buf_r1 (
    .clk_i   (i_clk),
    .we_i    (take),
    .addr_i  (addr),
    .wdata_i (i_pixel),
    .rdata_o (r1_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_W), .ADDR_W(COL_W)) u_buf_r2 (
    .clk_i   (i_clk),
    .we_i    (take),
    .addr_i  (addr),
    .wdata_i (r1_rd),
    .rdata_o (r2_rd)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q            <= S_IDLE;
      col_q              <= '0;
      row_q              <= '0;
      top_q              <= '0;
      mid_q              <= '0;
      bot_q              <= '0;
      o_pixel_data       <= '0;
      o_pixel_data_valid <= 1'b0;
      o_frame_done       <= 1'b0;
    end else begin
      o_pixel_data_valid <= 1'b0;
      o_frame_done       <= 1'b0;
      if (take) begin
        top_q <= {r2_rd, top_q[1]};
        mid_q <= {r1_rd, mid_q[1]};
        bot_q <= {i_pixel, bot_q[1]};
        if (i_sof) begin
          // Start-of-frame overrides any position, including the last pixel of a frame.
          state_q <= S_FILL;
          row_q   <= '0;
          col_q   <= COL_W'(1);
        end else begin
          if ((state_q == S_ACTIVE) && (col_q >= COL_W'(2))) begin
            o_pixel_data_valid <= 1'b1;
            o_pixel_data       <= win_d;
          end
          if (last_col) begin
            col_q <= '0;
            if (last_row) begin
              row_q        <= '0;
              state_q      <= S_IDLE;
              o_frame_done <= 1'b1;
            end else begin
              row_q <= row_q + ROW_W'(1);
              if (row_q == ROW_W'(1)) state_q <= S_ACTIVE;
            end
          end else begin
            col_q <= col_q + COL_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_line_window_gen.sv
// Bench for line_window_gen: table of known windows, directed corner cases, random stream vs model.
module tb_line_window_gen;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int DW = 8;
  localparam int OW = 9 * DW;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_pixel_valid = 1'b0;
  logic          i_sof = 1'b0;
  logic [DW-1:0] i_pixel = '0;
  logic [OW-1:0] o_pixel_data;
  logic          o_pixel_data_valid;
  logic          o_frame_done;

  line_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
    .i_clk              (clk),
    .i_rst              (i_rst),
    .i_pixel            (i_pixel),
    .i_pixel_valid      (i_pixel_valid),
    .i_sof              (i_sof),
    .o_pixel_data       (o_pixel_data),
    .o_pixel_data_valid (o_pixel_data_valid),
    .o_frame_done       (o_frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: image positions from the raster rules, windows read from a stored picture.
  logic [DW-1:0] img [H][W];
  bit            m_active = 1'b0;
  int            m_r = 0;
  int            m_c = 0;
  logic [OW-1:0] exp_data  = '0;
  logic          exp_valid = 1'b0;
  logic          exp_done  = 1'b0;

  logic [OW-1:0] got_q [$];
  int            done_cnt = 0;

  typedef struct {
    int          r;
    int          c;
    logic [OW-1:0] win;
  } win_rec_t;
  win_rec_t tbl [6];

  task automatic chk(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] window_at(input int r, input int c);
    logic [OW-1:0] w;
    w = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w[(dr*3+dc)*DW +: DW] = img[r-2+dr][c-2+dc];
    return w;
  endfunction

  task automatic model(input logic v, input logic s, input logic [DW-1:0] p, input logic r);
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    if (r) begin
      m_active = 1'b0; m_r = 0; m_c = 0; exp_data = '0;
      return;
    end
    if (!v) return;
    if (s) begin
      m_active = 1'b1; m_r = 0; m_c = 0;
    end
    if (!m_active) return;
    img[m_r][m_c] = p;
    if (!s && m_r >= 2 && m_c >= 2) begin
      exp_valid = 1'b1;
      exp_data  = window_at(m_r, m_c);
    end
    if (m_c == W-1) begin
      m_c = 0;
      if (m_r == H-1) begin
        m_r = 0; m_active = 1'b0; exp_done = 1'b1;
      end else m_r++;
    end else m_c++;
  endtask

  task automatic step(input logic v, input logic s, input logic [DW-1:0] p, input logic r);
    i_pixel_valid = v; i_sof = s; i_pixel = p; i_rst = r;
    model(v, s, p, r);
    @(posedge clk);
    #1;
    chk("valid", OW'(o_pixel_data_valid), OW'(exp_valid));
    chk("frame_done", OW'(o_frame_done), OW'(exp_done));
    chk("data", o_pixel_data, exp_data);
    if (o_pixel_data_valid) got_q.push_back(o_pixel_data);
    if (o_frame_done) done_cnt++;
  endtask

  // Sends raster indices [first, last) of a frame; pixel value row*16+col unless rnd.
  task automatic send_range(input int first, input int last, input int gap_max, input bit rnd);
    for (int idx = first; idx < last; idx++) begin
      int r, c;
      r = idx / W;
      c = idx % W;
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) step(1'b0, 1'b0, DW'($urandom), 1'b0);
      step(1'b1, idx == 0, rnd ? DW'($urandom) : DW'(r*16 + c), 1'b0);
    end
  endtask

  task automatic check_table(input string tag);
    chk({tag, "_count"}, OW'(got_q.size()), OW'(6));
    for (int i = 0; i < 6; i++)
      if (i < got_q.size()) chk($sformatf("%s_win_%0d_%0d", tag, tbl[i].r, tbl[i].c), got_q[i], tbl[i].win);
    chk({tag, "_done_cnt"}, OW'(done_cnt), OW'(1));
    got_q.delete();
    done_cnt = 0;
  endtask

  initial begin
    tbl[0] = '{2, 2, 72'h22_21_20_12_11_10_02_01_00};
    tbl[1] = '{2, 3, 72'h23_22_21_13_12_11_03_02_01};
    tbl[2] = '{2, 4, 72'h24_23_22_14_13_12_04_03_02};
    tbl[3] = '{3, 2, 72'h32_31_30_22_21_20_12_11_10};
    tbl[4] = '{3, 3, 72'h33_32_31_23_22_21_13_12_11};
    tbl[5] = '{3, 4, 72'h34_33_32_24_23_22_14_13_12};

    // Reset
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("rst_data", o_pixel_data, '0);
    chk("rst_valid", OW'(o_pixel_data_valid), '0);
    chk("rst_done", OW'(o_frame_done), '0);
    step(1'b0, 1'b0, '0, 1'b0);

    // Continuous full frame
    send_range(0, W*H, 0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    check_table("full");

    // Random valid gaps
    send_range(0, W*H, 3, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    check_table("gaps");

    // Pixels without sof are dropped
    repeat (7) step(1'b1, 1'b0, DW'($urandom), 1'b0);
    send_range(0, W*H, 0, 1'b0);
    check_table("drop");

    // sof reasserted at (2,3)
    send_range(0, 2*W + 3, 0, 1'b0);
    chk("abort_pre_count", OW'(got_q.size()), OW'(1));
    if (got_q.size() > 0) chk("abort_pre_win", got_q[0], tbl[0].win);
    got_q.delete();
    step(1'b1, 1'b1, 8'h00, 1'b0);
    chk("abort_restart_novalid", OW'(o_pixel_data_valid), '0);
    send_range(1, W*H, 0, 1'b0);
    check_table("abort");

    // Reset mid-frame at (3,1)
    send_range(0, 3*W + 1, 0, 1'b0);
    step(1'b1, 1'b0, 8'h31, 1'b1);
    chk("midrst_data", o_pixel_data, '0);
    chk("midrst_valid", OW'(o_pixel_data_valid), '0);
    step(1'b1, 1'b0, 8'h55, 1'b0);
    chk("midrst_nosof_novalid", OW'(o_pixel_data_valid), '0);
    got_q.delete();
    done_cnt = 0;
    send_range(0, W*H, 0, 1'b0);
    check_table("midrst");

    // Back-to-back frames, first one random
    send_range(0, W*H, 0, 1'b1);
    chk("b2b_first_done", OW'(done_cnt), OW'(1));
    got_q.delete();
    done_cnt = 0;
    send_range(0, W*H, 0, 1'b0);
    check_table("b2b");

    // Random stream against the model
    for (int i = 0; i < 3000; i++)
      step(($urandom % 4) != 0, ($urandom % 40) == 0, DW'($urandom), ($urandom % 400) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
